// File: rtl/seq_divider16.sv
// Sequential 16-bit unsigned restoring divider.
// One quotient bit per clock, MSB first. A start with a zero divisor skips
// iteration and reports saturated results with div_by_zero set.
//
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | iterating, one restoring step per cycle (16 cycles)
// DONE  | results valid for one cycle; start here chains the next operation
module seq_divider16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] dvd_sh;
  logic [15:0] dvs_q;
  logic [14:0] quo_w;
  logic [16:0] rem_w;
  logic [4:0]  step;

  logic [17:0] shifted;
  logic [17:0] trial;
  logic        q_bit;
  logic [16:0] rem_nxt;
  logic        last_step;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The extra top bit of the subtraction serves as the borrow/sign.
  always_comb begin
    shifted   = {rem_w, dvd_sh[15]};
    trial     = shifted - {2'b00, dvs_q};
    q_bit     = ~trial[17];
    rem_nxt   = q_bit ? trial[16:0] : shifted[16:0];
    last_step = (step == 5'd15);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; IDLE and DONE accept start with equal priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == 16'd0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture at start, iteration in CALC, results loaded only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh      <= '0;
      dvs_q       <= '0;
      quo_w       <= '0;
      rem_w       <= '0;
      step        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != 16'd0) begin
              dvd_sh      <= dividend;
              dvs_q       <= divisor;
              quo_w       <= '0;
              rem_w       <= '0;
              step        <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= 16'hFFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_w  <= rem_nxt;
          quo_w  <= {quo_w[13:0], q_bit};
          dvd_sh <= {dvd_sh[14:0], 1'b0};
          step   <= step + 5'd1;
          if (last_step) begin
            quotient  <= {quo_w, q_bit};
            remainder <= rem_nxt[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: doc/seq_divider16.md
SEQ_DIVIDER16 -- requirements
Module: seq_divider16

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to begin a division, sampled on the rising edge of clk.
REQ-004 SHALL have port dividend, input, 16 bits: unsigned dividend, sampled with start.
REQ-005 SHALL have port divisor, input, 16 bits: unsigned divisor, sampled with start.
REQ-006 SHALL have port quotient, output, 16 bits: unsigned quotient, registered.
REQ-007 SHALL have port remainder, output, 16 bits: unsigned remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is iterating.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-010 SHALL have port div_by_zero, output, 1 bit: flag qualifying the current results; divisor was 0.

Function
REQ-011 SHALL implement the FSM with states IDLE, CALC and DONE; busy = (state==CALC) and done = (state==DONE).
REQ-012 SHALL, in IDLE or DONE with start=1 and divisor!=0, latch the operands at that edge (T0), clear the working remainder, and enter CALC.
REQ-013 SHALL, in IDLE or DONE with start=1 and divisor==0, enter DONE at T0 with quotient=16'hFFFF, remainder=dividend and div_by_zero=1.
REQ-014 SHALL, in IDLE or DONE with start=0, go to (or stay in) IDLE, holding all result outputs.
REQ-015 SHALL, in CALC, ignore start; operands captured at T0 stay in use regardless of input changes.
REQ-016 SHALL, in CALC, perform one restoring step per cycle, MSB first: shift the partial remainder left one bit, shift in the next dividend bit, then perform a 17-bit trial subtraction of the divisor.
REQ-017 SHALL, when the trial result is non-negative, take that result as the new partial remainder and set the quotient bit to 1; otherwise it SHALL keep the shifted value and set the quotient bit to 0.
REQ-018 SHALL keep the partial remainder 17 bits wide so that divisors >= 16'h8000 cannot overflow.
REQ-019 SHALL use a 5-bit step counter, load it to 0 at T0, and leave CALC for DONE on the edge that completes step 16 (T16); done SHALL be high during the cycle after T16.
REQ-020 SHALL update quotient and remainder only on entry to DONE; they SHALL hold their last values at all other times, including during CALC.
REQ-021 SHALL clear div_by_zero on every accepted start whose divisor is nonzero.
REQ-022 SHALL give start in DONE (the done cycle) equal priority to start in IDLE, allowing back-to-back operations with no idle gap.
REQ-023 SHALL guarantee quotient*divisor + remainder == dividend and remainder < divisor for every divisor!=0.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, force state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and step counter=0.
REQ-025 SHALL give rst priority over start and over any in-progress CALC; an aborted division SHALL produce no done pulse.
REQ-026 SHALL ignore start sampled at an edge where rst=1.

Verification
REQ-027 SHALL pass directed test: start with 100/7 -> busy for 16 cycles, then done=1 for 1 cycle with quotient=14, remainder=2, div_by_zero=0.
REQ-028 SHALL pass directed test: 16'hFFFF/16'h8000 -> quotient=1, remainder=16'h7FFF; 3/16'h8001 -> quotient=0, remainder=3; 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0.
REQ-029 SHALL pass directed test: 5/0 -> done in the cycle after T0, quotient=16'hFFFF, remainder=5, div_by_zero=1; a following 9/3 clears div_by_zero and gives quotient=3, remainder=0.
REQ-030 SHALL pass directed test: start 1000/10, then pulse start with 50/5 at step 8 -> second request ignored; result quotient=100, remainder=0 at the usual latency.
REQ-031 SHALL pass directed test: assert rst at step 10 of 1000/10 -> next cycle all outputs 0, state IDLE, no done pulse; a subsequent 7/2 gives quotient=3, remainder=1.
REQ-032 SHALL pass directed test: start held high in the done cycle with new operands 20/6 -> the new operation begins with no idle gap and yields quotient=3, remainder=2.
